gate_resp_checker: RTL and testbench

Self-checking response monitor for the and/or/not gate block, sitting at the receiving end of the stimulus sequence. Samples each applied vector {a,b,c} and the observed outputs {t0,t1,t2}. Computes the expected values t0=a&b, t1=a|b and t2=~c, then compares expected against observed. Keeps pass/fail counters, a coverage map of the 8 input combinations, and first-failure capture, so a bench or on-chip sequencer gets a verdict with no waveform inspection.

---
 rtl/gate_resp_checker_pkg.sv | 18 +
 rtl/gate_resp_checker_if.sv | 34 +++
 rtl/gate_resp_checker_pipe.sv | 41 ++++
 rtl/gate_resp_checker.sv | 119 +++++++++++
 tb/tb_gate_resp_checker.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_resp_checker_pkg.sv
// Shared types and helpers for the gate response checker: FSM state encoding,
// the golden and/or/not function, and the deepest supported response latency.
package gate_chk_pkg;

    localparam int MAX_LAT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] exp_out(input logic a, input logic b, input logic c);
        return {a & b, a | b, ~c};
    endfunction

endpackage

// File: rtl/gate_resp_checker_if.sv
// Stimulus/response and verdict bundle between a sequencer (master) and the
// gate response checker (slave).
interface gate_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             vld;
    logic             a;
    logic             b;
    logic             c;
    logic             t0;
    logic             t1;
    logic             t2;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [7:0]       cov;
    logic             all_cov;
    logic             err;
    logic [2:0]       ff_vec;
    logic [2:0]       ff_bits;

    modport master (
        output start, stop, vld, a, b, c, t0, t1, t2,
        input  busy, done, pass_cnt, fail_cnt, cov, all_cov, err, ff_vec, ff_bits
    );

    modport slave (
        input  start, stop, vld, a, b, c, t0, t1, t2,
        output busy, done, pass_cnt, fail_cnt, cov, all_cov, err, ff_vec, ff_bits
    );
endinterface

// File: rtl/gate_resp_checker_pipe.sv
// LAT-deep {vld,vec} delay line aligning stimulus with the DUT response.
// LAT=0 is a combinational pass-through.
module gate_chk_pipe #(
    parameter int LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_vld,
    input  logic [2:0] i_vec,
    output logic       o_vld,
    output logic [2:0] o_vec
);
    if (LAT == 0) begin : g_thru
        logic w_unused;
        assign w_unused = ^{clk, rst, i_clr};
        assign o_vld    = i_vld;
        assign o_vec    = i_vec;
    end else begin : g_dly
        logic [LAT-1:0] r_vld_p;
        logic [2:0]     r_vec_p [LAT];

        // Only the valids are cleared; stale data behind a cleared valid is never compared.
        always_ff @(posedge clk) begin
            if (rst || i_clr) begin
                r_vld_p <= '0;
            end else begin
                r_vld_p[0] <= i_vld;
                for (int i = 1; i < LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
            end
        end

        always_ff @(posedge clk) begin
            r_vec_p[0] <= i_vec;
            for (int i = 1; i < LAT; i++) r_vec_p[i] <= r_vec_p[i-1];
        end

        assign o_vld = r_vld_p[LAT-1];
        assign o_vec = r_vec_p[LAT-1];
    end
endmodule

// File: rtl/gate_resp_checker.sv
// Response monitor for the and/or/not gate block: pass/fail counters, input
// coverage and first-failure capture. Define GATE_CHK_HALT_EN to stop at the first mismatch.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int LAT   = 0
) (
    input logic               clk,
    input logic               rst,
    gate_resp_checker_if.slave bus
);
    localparam int DRAIN_W = $clog2(MAX_LAT + 1);

    state_t             r_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [7:0]         r_cov;
    logic               r_err;
    logic [2:0]         r_ff_vec;
    logic [2:0]         r_ff_bits;

    logic       w_in_vld;
    logic       w_clr;
    logic       w_pipe_vld;
    logic [2:0] w_pipe_vec;
    logic       w_cmp;
    logic [2:0] w_mask;
    logic       w_pass;
    logic       w_halt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_in_vld = bus.vld && (r_state == RUN);
    assign w_clr    = bus.start || w_halt;

    gate_chk_pipe #(.LAT(LAT)) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_vld (w_in_vld),
        .i_vec ({bus.a, bus.b, bus.c}),
        .o_vld (w_pipe_vld),
        .o_vec (w_pipe_vec)
    );

    // Case equality makes an X/Z response count as a mismatch in simulation.
    assign w_cmp  = w_pipe_vld && !bus.start && ((r_state == RUN) || (r_state == DRAIN));
    assign w_mask = {bus.t0, bus.t1, bus.t2} ^ exp_out(w_pipe_vec[2], w_pipe_vec[1], w_pipe_vec[0]);
    assign w_pass = (w_mask === 3'b000);

`ifdef GATE_CHK_HALT_EN
    assign w_halt = w_cmp && !w_pass && !r_err;
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else if (bus.start) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else if (w_halt) begin
            r_state <= DONE;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.stop) begin
                        r_state     <= (LAT == 0) ? DONE : DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_W'(LAT - 1)) r_state <= DONE;
                    else                                  r_drain_cnt <= r_drain_cnt + 1'b1;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_cov      <= '0;
            r_err      <= 1'b0;
            r_ff_vec   <= '0;
            r_ff_bits  <= '0;
        end else if (w_cmp) begin
            r_cov[w_pipe_vec] <= 1'b1;
            if (w_pass) begin
                r_pass_cnt <= sat_inc(r_pass_cnt);
            end else begin
                r_fail_cnt <= sat_inc(r_fail_cnt);
                r_err      <= 1'b1;
                if (!r_err) begin
                    r_ff_vec  <= w_pipe_vec;
                    r_ff_bits <= w_mask;
                end
            end
        end
    end

    assign bus.busy     = (r_state == RUN) || (r_state == DRAIN);
    assign bus.done     = (r_state == DONE);
    assign bus.pass_cnt = r_pass_cnt;
    assign bus.fail_cnt = r_fail_cnt;
    assign bus.cov      = r_cov;
    assign bus.all_cov  = &r_cov;
    assign bus.err      = r_err;
    assign bus.ff_vec   = r_ff_vec;
    assign bus.ff_bits  = r_ff_bits;
endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: three checkers (LAT=0, LAT=2, LAT=0 with 2-bit
// counters) observe one stimulus stream driven through a behavioural gate model.
module tb_gate_resp_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_resp_checker_if #(.CNT_W(8)) if0 ();
    gate_resp_checker_if #(.CNT_W(8)) if2 ();
    gate_resp_checker_if #(.CNT_W(2)) ifs ();

    gate_resp_checker #(.CNT_W(8), .LAT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    gate_resp_checker #(.CNT_W(8), .LAT(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    gate_resp_checker #(.CNT_W(2), .LAT(0)) us (.clk(clk), .rst(rst), .bus(ifs));

    logic       s_start, s_stop, s_vld;
    logic [2:0] s_vec, t_l0, t_l2;

    assign if0.start = s_start; assign if0.stop = s_stop; assign if0.vld = s_vld;
    assign if2.start = s_start; assign if2.stop = s_stop; assign if2.vld = s_vld;
    assign ifs.start = s_start; assign ifs.stop = s_stop; assign ifs.vld = s_vld;
    assign {if0.a, if0.b, if0.c} = s_vec;
    assign {if2.a, if2.b, if2.c} = s_vec;
    assign {ifs.a, ifs.b, ifs.c} = s_vec;
    assign {if0.t0, if0.t1, if0.t2} = t_l0;
    assign {ifs.t0, ifs.t1, ifs.t2} = t_l0;
    assign {if2.t0, if2.t1, if2.t2} = t_l2;

    int checks = 0;
    int errors = 0;

    // Vectors accepted since the last start, and the fault mask the gate model applied to each.
    logic [2:0] q_vec[$];
    logic [2:0] q_inj[$];
    logic [2:0] h_vec[2];
    logic [2:0] h_inj[2];

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [7:0] pcnt;
        logic [7:0] fcnt;
        logic [7:0] cov;
        logic       all_cov;
        logic       err;
        logic [2:0] ff_vec;
        logic [2:0] ff_bits;
    } res_t;

    function automatic logic [2:0] gate(input logic [2:0] v);
        return {v[2] & v[1], v[2] | v[1], ~v[0]};
    endfunction

    function automatic res_t observe(input int d);
        res_t r;
        case (d)
            0: r = '{if0.busy, if0.done, if0.pass_cnt, if0.fail_cnt, if0.cov,
                     if0.all_cov, if0.err, if0.ff_vec, if0.ff_bits};
            1: r = '{if2.busy, if2.done, if2.pass_cnt, if2.fail_cnt, if2.cov,
                     if2.all_cov, if2.err, if2.ff_vec, if2.ff_bits};
            default: r = '{ifs.busy, ifs.done, 8'(ifs.pass_cnt), 8'(ifs.fail_cnt), ifs.cov,
                           ifs.all_cov, ifs.err, ifs.ff_vec, ifs.ff_bits};
        endcase
        return r;
    endfunction

    // Expected verdict from the list of accepted vectors and their fault masks.
    function automatic res_t model(input int d, input bit busy, input bit done);
        res_t r;
        int np, nf, mx;
        r  = '0;
        np = 0;
        nf = 0;
        mx = (d == 2) ? 3 : 255;
        for (int i = 0; i < q_vec.size(); i++) begin
            r.cov[q_vec[i]] = 1'b1;
            if (q_inj[i] == 3'b000) begin
                np++;
            end else begin
                nf++;
                if (!r.err) begin
                    r.err     = 1'b1;
                    r.ff_vec  = q_vec[i];
                    r.ff_bits = q_inj[i];
                end
`ifdef GATE_CHK_HALT_EN
                break;
`endif
            end
        end
        r.pcnt    = 8'((np > mx) ? mx : np);
        r.fcnt    = 8'((nf > mx) ? mx : nf);
        r.all_cov = (r.cov == 8'hFF);
        r.busy    = busy;
        r.done    = done;
        return r;
    endfunction

    task automatic step(input bit v, input logic [2:0] vec, input logic [2:0] inj,
                        input bit st, input bit sp);
        s_vld   = v;
        s_vec   = vec;
        s_start = st;
        s_stop  = sp;
        t_l0    = gate(vec) ^ inj;
        t_l2    = gate(h_vec[1]) ^ h_inj[1];
        h_vec[1] = h_vec[0]; h_inj[1] = h_inj[0];
        h_vec[0] = vec;      h_inj[0] = inj;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] vec, input logic [2:0] inj);
        q_vec.push_back(vec);
        q_inj.push_back(inj);
        step(1'b1, vec, inj, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        q_vec.delete();
        q_inj.delete();
        step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== res_t'(0)) begin
                errors++;
                $display("FAIL reset_held dut%0d got %p want %p", d, observe(d), res_t'(0));
            end
        end
        rst = 1'b0;
        idle(2);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== res_t'(0)) begin
                errors++;
                $display("FAIL reset_idle dut%0d got %p want %p", d, observe(d), res_t'(0));
            end
        end
    endtask

    task automatic test_directed();
        logic [2:0] vecs [6];
        vecs = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b000};
        do_start();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== model(d, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL start_run dut%0d got %p want %p", d, observe(d), model(d, 1'b1, 1'b0));
            end
        end
        for (int i = 0; i < 6; i++) send(vecs[i], 3'b000);
        step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        for (int d = 0; d < 3; d += 2) begin
            checks++;
            if (observe(d) !== model(d, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL directed_stop dut%0d got %p want %p", d, observe(d), model(d, 1'b0, 1'b1));
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({if2.busy, if2.done} !== 2'b10) begin
                errors++;
                $display("FAIL drain_busy cycle%0d got busy/done %b want 10", k, {if2.busy, if2.done});
            end
            if (k == 0) idle(1);
        end
        idle(1);
        checks++;
        if (observe(1) !== model(1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL drain_done dut1 got %p want %p", observe(1), model(1, 1'b0, 1'b1));
        end
        // A vector offered in DONE must leave every result untouched.
        step(1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
        idle(3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== model(d, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL done_hold dut%0d got %p want %p", d, observe(d), model(d, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_all_cov();
        do_start();
        for (int v = 0; v < 8; v++) send(3'(v), 3'b000);
        step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        idle(4);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== model(d, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL all_cov dut%0d got %p want %p", d, observe(d), model(d, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_stuck_t1();
        logic [2:0] vecs [3];
        logic [2:0] g;
        vecs = '{3'b000, 3'b110, 3'b011};
        do_start();
        for (int i = 0; i < 3; i++) begin
            g = gate(vecs[i]);
            send(vecs[i], g[1] ? 3'b010 : 3'b000);
        end
        step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        idle(4);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== model(d, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL stuck_t1 dut%0d got %p want %p", d, observe(d), model(d, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 8; it++) begin
            do_start();
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(3'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
            end
            step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
            idle(4);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (observe(d) !== model(d, 1'b0, 1'b1)) begin
                    errors++;
                    $display("FAIL random%0d dut%0d got %p want %p", it, d, observe(d), model(d, 1'b0, 1'b1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        for (int i = 0; i < 3; i++) send(3'($urandom_range(0, 7)), 3'b001);
        do_start();
        for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 7)), 3'b000);
        step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        idle(4);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== model(d, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL restart dut%0d got %p want %p", d, observe(d), model(d, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_rst_midrun();
        do_start();
        for (int i = 0; i < 3; i++) send(3'($urandom_range(0, 7)), 3'b000);
        rst = 1'b1;
        idle(1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== res_t'(0)) begin
                errors++;
                $display("FAIL rst_midrun dut%0d got %p want %p", d, observe(d), res_t'(0));
            end
        end
        rst = 1'b0;
        step(1'b1, 3'b101, 3'b000, 1'b0, 1'b0);
        idle(3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observe(d) !== res_t'(0)) begin
                errors++;
                $display("FAIL idle_vld dut%0d got %p want %p", d, observe(d), res_t'(0));
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_start = 1'b0;
        s_stop  = 1'b0;
        s_vld   = 1'b0;
        s_vec   = 3'b000;
        t_l0    = 3'b000;
        t_l2    = 3'b000;
        h_vec   = '{3'b000, 3'b000};
        h_inj   = '{3'b000, 3'b000};
        test_reset();
        test_directed();
        test_all_cov();
        test_stuck_t1();
        test_random();
        test_back_to_back();
        test_rst_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
